// File: rtl/derivador_pkg.sv
// Shared defaults, result limits and datapath types for the multichannel differentiator.
// Saturation is selected at build time with DERIVADOR_SAT_EN (see escalador_sat).
package derivador_pkg;

    localparam int unsigned DEF_W    = 19;
    localparam int unsigned DEF_FRAC = 8;
    localparam int unsigned DEF_NCH  = 4;

    localparam logic signed [DEF_W-1:0] DK_MAX = {1'b0, {(DEF_W-1){1'b1}}};
    localparam logic signed [DEF_W-1:0] DK_MIN = {1'b1, {(DEF_W-1){1'b0}}};

    typedef logic signed [DEF_W-1:0] sample_t;
    typedef logic signed [DEF_W:0]   diff_t;
    typedef logic signed [2*DEF_W:0] prod_t;

    // Channel index needs at least one bit even for a single channel.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/escalador_sat.sv
// Drops the FRAC gain fraction bits and reduces the product to W bits.
// DERIVADOR_SAT_EN defined: clip to the W-bit range and flag ovf; otherwise wrap, ovf=0.
module escalador_sat
    import derivador_pkg::*;
#(
    parameter int unsigned W    = DEF_W,
    parameter int unsigned FRAC = DEF_FRAC
) (
    input  logic signed [2*W:0] prod_i,
    output logic signed [W-1:0] dk_o,
    output logic                ovf_o
);

    logic signed [2*W:0] scaled;

    assign scaled = prod_i >>> FRAC;

`ifdef DERIVADOR_SAT_EN
    logic in_range;

    // Fits in W bits iff every bit above the result repeats the sign.
    assign in_range = (scaled[2*W:W-1] == {(W+2){scaled[2*W]}});

    always_comb begin
        dk_o  = scaled[W-1:0];
        ovf_o = 1'b0;
        if (!in_range) begin
            ovf_o = 1'b1;
            dk_o  = scaled[2*W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end
`else
    logic unused_scaled_hi;

    assign unused_scaled_hi = ^scaled[2*W:W];
    assign dk_o             = scaled[W-1:0];
    assign ovf_o            = 1'b0;
`endif

endmodule

// File: rtl/derivador_multicanal.sv
// Time-multiplexed per-channel differentiator: dk = (y[n] - y[n-1]) * gain, two-stage pipeline.
// Output reduction (wrap or saturate) is selected by DERIVADOR_SAT_EN inside escalador_sat.
module derivador_multicanal
    import derivador_pkg::*;
#(
    parameter int unsigned W    = DEF_W,
    parameter int unsigned FRAC = DEF_FRAC,
    parameter int unsigned NCH  = DEF_NCH,
    localparam int unsigned CW  = ch_width(NCH)
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                Enable,
    input  logic                in_valid,
    input  logic [CW-1:0]       in_ch,
    input  logic signed [W-1:0] y,
    input  logic signed [W-1:0] gain,
    output logic                out_valid,
    output logic [CW-1:0]       out_ch,
    output logic signed [W-1:0] dk,
    output logic                ovf
);

    localparam logic [CW:0] NCH_LIM = (CW+1)'(NCH);

    logic signed [W-1:0] prev_q [NCH];
    logic [NCH-1:0]      primed_q;

    logic                accept;
    logic signed [W:0]   diff_d, diff_q;
    logic signed [W-1:0] gain_q;
    logic [CW-1:0]       ch_q;
    logic                v1_q;

    logic signed [2*W:0] prod;
    logic signed [W-1:0] dk_d;
    logic                ovf_d;

    assign accept = Enable && in_valid && ({1'b0, in_ch} < NCH_LIM);

    // An unprimed channel has no history, so its first derivative is defined as zero.
    always_comb begin
        diff_d = '0;
        if (accept && primed_q[in_ch]) begin
            diff_d = $signed({y[W-1], y}) - $signed({prev_q[in_ch][W-1], prev_q[in_ch]});
        end
    end

    assign prod = $signed({{W{diff_q[W]}}, diff_q}) * $signed({{(W+1){gain_q[W-1]}}, gain_q});

    escalador_sat #(
        .W    (W),
        .FRAC (FRAC)
    ) u_escalador_sat (
        .prod_i (prod),
        .dk_o   (dk_d),
        .ovf_o  (ovf_d)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                prev_q[i] <= '0;
            end
            primed_q  <= '0;
            v1_q      <= 1'b0;
            diff_q    <= '0;
            gain_q    <= '0;
            ch_q      <= '0;
            out_valid <= 1'b0;
            dk        <= '0;
            out_ch    <= '0;
            ovf       <= 1'b0;
        end else if (Enable) begin
            v1_q <= accept;
            if (accept) begin
                prev_q[in_ch]   <= y;
                primed_q[in_ch] <= 1'b1;
                diff_q          <= diff_d;
                gain_q          <= gain;
                ch_q            <= in_ch;
            end
            out_valid <= v1_q;
            if (v1_q) begin
                dk     <= dk_d;
                out_ch <= ch_q;
                ovf    <= ovf_d;
            end
        end
    end

endmodule

// File: tb/tb_derivador_multicanal.sv
// Scoreboard bench for derivador_multicanal (NCH=3): directed plan cases plus random traffic.
// Expected results follow DERIVADOR_SAT_EN the same way the design build does.
module tb_derivador_multicanal;

    localparam int W    = 19;
    localparam int FRAC = 8;
    localparam int NCH  = 3;
    localparam int CW   = 2;
    localparam int G150 = 38400;

    localparam longint DMAX = (64'sd1 <<< (W - 1)) - 1;
    localparam longint DMIN = -(64'sd1 <<< (W - 1));
    localparam longint MODW = 64'sd1 <<< W;

    logic                CLK = 1'b0;
    logic                Reset, Enable, in_valid;
    logic [CW-1:0]       in_ch;
    logic signed [W-1:0] y, gain;
    logic                out_valid, ovf;
    logic [CW-1:0]       out_ch;
    logic signed [W-1:0] dk;

    typedef struct {
        int     ch;
        longint dk;
        bit     ovf;
        int     stamp;
    } exp_t;

    exp_t q[$];
    exp_t last_exp;
    int   prev_m [NCH];
    bit   primed_m [NCH];
    int   cnt   = 0;
    int   total = 0;
    int   bad   = 0;
    bit   en_s, rst_s;

    always #5 CLK = ~CLK;

    derivador_multicanal #(
        .W    (W),
        .FRAC (FRAC),
        .NCH  (NCH)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .Enable    (Enable),
        .in_valid  (in_valid),
        .in_ch     (in_ch),
        .y         (y),
        .gain      (gain),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .dk        (dk),
        .ovf       (ovf)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: exact integer product, floor division by 2^FRAC, then clip or wrap.
    function automatic exp_t model(input int ch, input longint diff, input longint g);
        exp_t   e;
        longint scaled;
        scaled = (diff * g) >>> FRAC;
        e.ch   = ch;
        e.ovf  = 1'b0;
`ifdef DERIVADOR_SAT_EN
        if (scaled > DMAX) begin
            e.dk  = DMAX;
            e.ovf = 1'b1;
        end else if (scaled < DMIN) begin
            e.dk  = DMIN;
            e.ovf = 1'b1;
        end else begin
            e.dk = scaled;
        end
`else
        e.dk = scaled % MODW;
        if (e.dk < 0) e.dk += MODW;
        if (e.dk > DMAX) e.dk -= MODW;
`endif
        e.stamp = 0;
        return e;
    endfunction

    task automatic drive(input bit v, input int ch, input int yv, input int g, input bit en);
        exp_t   e;
        longint diff;
        #1;
        Reset    = 1'b0;
        Enable   = en;
        in_valid = v;
        in_ch    = ch[CW-1:0];
        y        = yv[W-1:0];
        gain     = g[W-1:0];
        @(posedge CLK);
        if (en && v && ch < NCH) begin
            diff         = primed_m[ch] ? longint'(yv) - longint'(prev_m[ch]) : 0;
            prev_m[ch]   = yv;
            primed_m[ch] = 1'b1;
            e            = model(ch, diff, g);
            e.stamp      = cnt;
            q.push_back(e);
            last_exp = e;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 0, 0, 1'b1);
    endtask

    task automatic do_reset(input int n);
        #1;
        Reset    = 1'b1;
        Enable   = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        in_ch    = '0;
        y        = 19'sd12345;
        gain     = 19'(G150);
        repeat (n) @(posedge CLK);
        q.delete();
        for (int i = 0; i < NCH; i++) begin
            prev_m[i]   = 0;
            primed_m[i] = 1'b0;
        end
        #1;
        Reset    = 1'b0;
        in_valid = 1'b0;
        Enable   = 1'b1;
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_dk", longint'($signed(dk)), 0);
        chk("reset_out_ch", longint'(out_ch), 0);
        chk("reset_ovf", longint'(ovf), 0);
    endtask

    // Monitor: counts enabled edges and checks every fresh result against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            en_s  = Enable;
            rst_s = Reset;
            if (Enable) cnt++;
            @(posedge CLK);
            #1;
            if (en_s && !rst_s) begin
                if (out_valid) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_result: got ch=%0d dk=%0d, expected no result",
                                 out_ch, dk);
                    end else begin
                        e = q.pop_front();
                        chk("dk", longint'($signed(dk)), e.dk);
                        chk("out_ch", longint'(out_ch), longint'(e.ch));
                        chk("ovf", longint'(ovf), longint'(e.ovf));
                        chk("latency_edge", longint'(cnt), longint'(e.stamp + 1));
                    end
                end else if (q.size() > 0 && cnt >= q[0].stamp + 1) begin
                    total++;
                    bad++;
                    $display("FAIL missing_result: got out_valid=0 expected ch=%0d dk=%0d",
                             q[0].ch, q[0].dk);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        exp_t hold;
        int   yv, gv;
        Reset    = 1'b1;
        Enable   = 1'b0;
        in_valid = 1'b0;
        in_ch    = '0;
        y        = '0;
        gain     = '0;
        do_reset(2);

        // Basic ch0
        drive(1'b1, 0, 100, G150, 1'b1);
        drive(1'b1, 0, 110, G150, 1'b1);
        idle(3);

        // Interleaved channels
        do_reset(1);
        drive(1'b1, 0, 100, G150, 1'b1);
        drive(1'b1, 1, 5000, G150, 1'b1);
        drive(1'b1, 0, 110, G150, 1'b1);
        drive(1'b1, 1, 4990, G150, 1'b1);
        idle(3);

        // Overflow in both directions on ch2
        drive(1'b1, 2, 0, G150, 1'b1);
        drive(1'b1, 2, 200000, G150, 1'b1);
        drive(1'b1, 2, 0, G150, 1'b1);
        idle(3);

        // Stall with a result in stage 1; stalled samples must be dropped
        do_reset(1);
        drive(1'b1, 1, 5000, G150, 1'b1);
        drive(1'b1, 1, 4990, G150, 1'b1);
        hold = last_exp;
        drive(1'b1, 0, 300, G150, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 0, 9000 + i * 1000, G150, 1'b0);
            #1;
            chk("stall_out_valid", longint'(out_valid), 1);
            chk("stall_dk", longint'($signed(dk)), hold.dk);
            chk("stall_out_ch", longint'(out_ch), longint'(hold.ch));
        end
        drive(1'b1, 0, 310, G150, 1'b1);
        idle(3);

        // Out-of-range channel is ignored
        drive(1'b1, 3, 777, G150, 1'b1);
        drive(1'b1, 0, 320, G150, 1'b1);
        idle(3);

        // Reset with both stages full
        drive(1'b1, 0, 400, G150, 1'b1);
        drive(1'b1, 1, 500, G150, 1'b1);
        do_reset(1);
        drive(1'b1, 0, 50, G150, 1'b1);
        idle(3);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            yv = int'($urandom_range(0, 524287)) - 262144;
            if ($urandom_range(0, 1) == 1) gv = int'($urandom_range(0, 524287)) - 262144;
            else gv = int'($urandom_range(0, 2047)) - 1024;
            drive(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)), yv, gv,
                  1'($urandom_range(0, 9) != 0));
        end
        idle(4);

        chk("queue_drained", longint'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
